// File: rtl/cmd_send_pkg.sv
// Shared definitions for the command send scheduler: FSM states and defaults.
package cmd_send_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_GAP_CYC     = 4;

  typedef enum logic [2:0] {
    ST_WAIT_CAL,
    ST_SETUP,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_FAIL
  } state_t;

  // Index width that stays legal (at least one bit) even for a count of one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from the requester after the
// last winner and returns a one-hot grant (all zero when nobody requests).
module rr_arbiter
  import cmd_send_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  // Walk the requesters in rotating priority order and keep the first hit.
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_send_sched.sv
// Command send scheduler: brings the DDR up after calibration, then hands
// requester commands to the PCIe command sender one at a time, round-robin,
// with a timeout on every handshake and an idle gap between commands.
module cmd_send_sched
  import cmd_send_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ddr_local_cal_success,
  input  logic                      ddr_local_cal_fail,
  input  logic                      ddr_setup_done,
  output logic                      ddr_setup_cmd,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         start_ram_addr,
  output logic                      send_cmd,
  input  logic                      cmd_done,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      err_cal_fail
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [ADDR_W-1:0]    grant_addr;
  logic                 grant_fire;
  logic                 timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Turn the one-hot grant into an index and pick that requester's address.
  always_comb begin
    grant_idx  = '0;
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx  = IDX_W'(i);
        grant_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAIT_CAL;
    else     state <= state_next;
  end

  // Next state; a calibration failure beats every other transition.
  always_comb begin
    state_next  = state;
    grant_fire  = 1'b0;
    timeout_hit = 1'b0;
    if (state != ST_FAIL && ddr_local_cal_fail) begin
      state_next = ST_FAIL;
    end else begin
      case (state)
        ST_WAIT_CAL:  if (ddr_local_cal_success) state_next = ST_SETUP;
        ST_SETUP: begin
          if (ddr_setup_done) begin
            state_next = ST_ARB;
          end else if (cnt == CNT_LAST) begin
            state_next  = ST_FAIL;
            timeout_hit = 1'b1;
          end
        end
        ST_ARB: begin
          if (!ddr_local_cal_success) begin
            state_next = ST_WAIT_CAL;
          end else if (|req_valid) begin
            state_next = ST_ISSUE;
            grant_fire = 1'b1;
          end
        end
        ST_ISSUE:     state_next = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (cmd_done) begin
            state_next = ST_GAP;
          end else if (cnt == CNT_LAST) begin
            state_next  = ST_GAP;
            timeout_hit = 1'b1;
          end
        end
        ST_GAP: begin
          if (!ddr_local_cal_success) state_next = ST_WAIT_CAL;
          else if (cnt == GAP_LAST)   state_next = ST_ARB;
        end
        ST_FAIL:      state_next = ST_FAIL;
        default:      state_next = ST_WAIT_CAL;
      endcase
    end
  end

  // Outputs; the setup strobe is Mealy and is forced low while in reset.
  always_comb begin
    ddr_setup_cmd = !rst && (state == ST_WAIT_CAL) && (state_next == ST_SETUP);
    req_ready     = grant_fire ? grant : '0;
    send_cmd      = (state == ST_ISSUE);
    busy          = (state == ST_SETUP) || (state == ST_ISSUE) ||
                    (state == ST_WAIT_DONE) || (state == ST_GAP);
  end

  // Cycle counter restarts on every state change and saturates instead of
  // wrapping; grant bookkeeping and sticky error flags live here too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      last_grant     <= IDX_W'(NUM_REQ - 1);
      start_ram_addr <= '0;
      err_timeout    <= 1'b0;
      err_cal_fail   <= 1'b0;
    end else begin
      if (state_next != state)  cnt <= '0;
      else if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
      if (grant_fire) begin
        last_grant     <= grant_idx;
        start_ram_addr <= grant_addr;
      end
      if (timeout_hit) err_timeout <= 1'b1;
      if (state != ST_FAIL && ddr_local_cal_fail) err_cal_fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_send_sched.sv
// Self-checking bench for cmd_send_sched: a timestamp-based model of the
// scheduler is compared against the DUT every cycle, with directed scenarios
// carrying hand-computed expectations and a randomized traffic phase.
module tb_cmd_send_sched;

  localparam int NUM_REQ     = 4;
  localparam int ADDR_W      = 6;
  localparam int TIMEOUT_CYC = 1024;
  localparam int GAP_CYC     = 4;
  localparam int GAP_LEN     = (GAP_CYC == 0) ? 1 : GAP_CYC;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      ddr_local_cal_success = 1'b0;
  logic                      ddr_local_cal_fail = 1'b0;
  logic                      ddr_setup_done = 1'b0;
  logic                      ddr_setup_cmd;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         start_ram_addr;
  logic                      send_cmd;
  logic                      cmd_done = 1'b0;
  logic                      busy;
  logic                      err_timeout;
  logic                      err_cal_fail;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Model: the scheduler is described by when things started, not by states.
  bit          m_failed, m_err_to, m_err_cf, m_online;
  int          setup_entry = -1;
  int          issue_at    = -1;
  int          gap_start   = -1;
  int          m_last      = NUM_REQ - 1;
  logic [ADDR_W-1:0] m_addr = '0;

  logic              obs_setup, obs_send, obs_busy, obs_err_to, obs_err_cf;
  logic [NUM_REQ-1:0] obs_ready;
  logic [ADDR_W-1:0]  obs_addr;

  cmd_send_sched #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ddr_local_cal_success (ddr_local_cal_success),
    .ddr_local_cal_fail    (ddr_local_cal_fail),
    .ddr_setup_done        (ddr_setup_done),
    .ddr_setup_cmd         (ddr_setup_cmd),
    .req_valid             (req_valid),
    .req_addr              (req_addr),
    .req_ready             (req_ready),
    .start_ram_addr        (start_ram_addr),
    .send_cmd              (send_cmd),
    .cmd_done              (cmd_done),
    .busy                  (busy),
    .err_timeout           (err_timeout),
    .err_cal_fail          (err_cal_fail)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_failed    = 1'b0;
    m_err_to    = 1'b0;
    m_err_cf    = 1'b0;
    m_online    = 1'b0;
    setup_entry = -1;
    issue_at    = -1;
    gap_start   = -1;
    m_last      = NUM_REQ - 1;
    m_addr      = '0;
  endtask

  // Compare every DUT output with the model for the current cycle, then
  // advance the model using this cycle's inputs.
  task automatic check_output();
    logic [NUM_REQ-1:0] exp_ready;
    logic exp_setup, exp_send, exp_busy;
    bit   in_setup, in_issue, in_wait, in_gap, in_arb, found;
    int   g;
    obs_setup  = ddr_setup_cmd;
    obs_ready  = req_ready;
    obs_send   = send_cmd;
    obs_busy   = busy;
    obs_addr   = start_ram_addr;
    obs_err_to = err_timeout;
    obs_err_cf = err_cal_fail;
    if (rst) begin
      expect_eq("reset_outputs",
                {ddr_setup_cmd, req_ready, send_cmd, busy, err_timeout, err_cal_fail, start_ram_addr}, 0);
      model_reset();
    end else begin
      expect_eq("start_ram_addr", start_ram_addr, m_addr);
      expect_eq("err_timeout", err_timeout, m_err_to);
      expect_eq("err_cal_fail", err_cal_fail, m_err_cf);
      exp_ready = '0;
      exp_setup = 1'b0;
      g         = 0;
      found     = 1'b0;
      in_setup  = setup_entry >= 0;
      in_issue  = issue_at == n;
      in_wait   = issue_at >= 0 && n > issue_at;
      in_gap    = gap_start >= 0;
      in_arb    = m_online && !in_setup && issue_at < 0 && !in_gap;
      exp_send  = !m_failed && in_issue;
      exp_busy  = !m_failed && (in_setup || in_issue || in_wait || in_gap);
      if (m_failed) begin
        exp_send = 1'b0;
      end else if (ddr_local_cal_fail) begin
        m_failed = 1'b1;
        m_err_cf = 1'b1;
      end else if (in_setup) begin
        if (ddr_setup_done) begin
          setup_entry = -1;
          m_online    = 1'b1;
        end else if (n - setup_entry == TIMEOUT_CYC - 1) begin
          m_failed    = 1'b1;
          m_err_to    = 1'b1;
          setup_entry = -1;
        end
      end else if (in_issue) begin
        exp_setup = 1'b0;
      end else if (in_wait) begin
        if (cmd_done || (n - issue_at - 1 == TIMEOUT_CYC - 1)) begin
          if (!cmd_done) m_err_to = 1'b1;
          issue_at  = -1;
          gap_start = n + 1;
        end
      end else if (in_gap) begin
        if (!ddr_local_cal_success) begin
          gap_start = -1;
          m_online  = 1'b0;
        end else if (n - gap_start == GAP_LEN - 1) begin
          gap_start = -1;
        end
      end else if (in_arb) begin
        if (!ddr_local_cal_success) begin
          m_online = 1'b0;
        end else if (req_valid != 0) begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(m_last + k) % NUM_REQ]) begin
              g     = (m_last + k) % NUM_REQ;
              found = 1'b1;
            end
          end
          exp_ready[g] = 1'b1;
          m_last       = g;
          m_addr       = req_addr[g*ADDR_W +: ADDR_W];
          issue_at     = n + 1;
        end
      end else if (ddr_local_cal_success) begin
        exp_setup   = 1'b1;
        setup_entry = n + 1;
      end
      expect_eq("ddr_setup_cmd", ddr_setup_cmd, exp_setup);
      expect_eq("req_ready", req_ready, exp_ready);
      expect_eq("send_cmd", send_cmd, exp_send);
      expect_eq("busy", busy, exp_busy);
    end
    n++;
  endtask

  // One clock: check at the falling edge, then drop any accepted requests.
  task automatic step_cycle();
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~obs_ready;
  endtask

  // Random traffic: requesters raise and hold, random completions, setup
  // acknowledgements and occasional loss of calibration.
  task automatic apply_stimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
        req_valid[i] = 1'b1;
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      end
    end
    cmd_done       = ($urandom_range(0, 5) == 0);
    ddr_setup_done = ($urandom_range(0, 7) == 0);
    if (ddr_local_cal_success && $urandom_range(0, 299) == 0) ddr_local_cal_success = 1'b0;
    else if (!ddr_local_cal_success && $urandom_range(0, 3) == 0) ddr_local_cal_success = 1'b1;
  endtask

  // Bring the DUT back to idle arbitration with nothing outstanding.
  task automatic settle();
    req_valid             = '0;
    ddr_local_cal_success = 1'b1;
    ddr_local_cal_fail    = 1'b0;
    ddr_setup_done        = 1'b1;
    cmd_done              = 1'b1;
    repeat (20) step_cycle();
    ddr_setup_done = 1'b0;
    cmd_done       = 1'b0;
    step_cycle();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) step_cycle();
    rst = 1'b0;
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    int pulses, pulse_cyc, busy_mid, ng, ns, last_send, first_err, seen;
    logic [NUM_REQ-1:0] grants[8];
    int sends[8];

    $display("[TB] start");
    repeat (3) step_cycle();
    expect_eq("reset_busy", obs_busy, 0);
    expect_eq("reset_addr", obs_addr, 0);
    expect_eq("reset_flags", {obs_err_to, obs_err_cf}, 0);
    rst = 1'b0;

    // Bring-up: calibration at cycle 5, setup done ten cycles later.
    pulses = 0; pulse_cyc = -1; busy_mid = 0;
    for (int c = 0; c < 20; c++) begin
      ddr_local_cal_success = (c >= 5);
      ddr_setup_done        = (c == 15);
      step_cycle();
      if (obs_setup) begin pulses++; pulse_cyc = c; end
      if (c == 10) busy_mid = obs_busy;
    end
    ddr_setup_done = 1'b0;
    expect_eq("bringup_pulse_count", pulses, 1);
    expect_eq("bringup_pulse_cycle", pulse_cyc, 5);
    expect_eq("bringup_busy_in_setup", busy_mid, 1);
    expect_eq("bringup_idle_in_arb", obs_busy, 0);

    // Fairness: everybody requesting, completion four cycles after each send.
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(8 * i + 1);
    ng = 0; ns = 0; last_send = -100;
    for (int c = 0; c < 50; c++) begin
      req_valid = '1;
      cmd_done  = (c == last_send + 4);
      step_cycle();
      if (obs_ready != 0 && ng < 8) begin grants[ng] = obs_ready; ng++; end
      if (obs_send && ns < 8) begin sends[ns] = c; ns++; last_send = c; end
    end
    expect_eq("fair_grant_count_ok", ng >= 5, 1);
    expect_eq("fair_grant0", grants[0], 4'b0001);
    expect_eq("fair_grant1", grants[1], 4'b0010);
    expect_eq("fair_grant2", grants[2], 4'b0100);
    expect_eq("fair_grant3", grants[3], 4'b1000);
    expect_eq("fair_grant4", grants[4], 4'b0001);
    // ISSUE + three quiet WAIT_DONE cycles + GAP + done cycle + ARB.
    expect_eq("fair_spacing_a", sends[1] - sends[0], 1 + 3 + GAP_CYC + 2);
    expect_eq("fair_spacing_b", sends[4] - sends[3], 1 + 3 + GAP_CYC + 2);
    settle();

    // Address: requester 2 alone.
    req_addr[2*ADDR_W +: ADDR_W] = 6'h2A;
    req_valid = 4'b0100;
    step_cycle();
    expect_eq("addr_ready", obs_ready, 4'b0100);
    step_cycle();
    expect_eq("addr_send", obs_send, 1);
    expect_eq("addr_value", obs_addr, 6'h2A);
    expect_eq("addr_ready_once", obs_ready, 0);
    settle();

    // Random traffic.
    ddr_local_cal_success = 1'b1;
    repeat (3000) begin
      apply_stimulus();
      step_cycle();
    end
    settle();

    // Timeout: no completion, error raised, next request still served.
    req_valid = 4'b0001;
    step_cycle();
    step_cycle();
    first_err = -1;
    for (int k = 1; k <= 1030; k++) begin
      step_cycle();
      if (obs_err_to && first_err < 0) first_err = k;
    end
    expect_eq("timeout_flag", obs_err_to, 1);
    expect_eq("timeout_latency", first_err, TIMEOUT_CYC + 1);
    req_valid = 4'b0010;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step_cycle();
      if (obs_ready == 4'b0010) seen++;
    end
    expect_eq("timeout_next_served", seen, 1);
    settle();

    // Reset aborts a command in flight; first grant afterwards goes to 0.
    req_valid = 4'b0010;
    repeat (3) step_cycle();
    pulse_reset();
    settle();
    req_valid = '1;
    step_cycle();
    expect_eq("post_reset_first_grant", obs_ready, 4'b0001);
    step_cycle();
    expect_eq("edge_send", obs_send, 1);

    // Completion on the very cycle the timeout expires counts as done.
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      cmd_done = (k == TIMEOUT_CYC);
      step_cycle();
    end
    cmd_done = 1'b0;
    step_cycle();
    expect_eq("edge_gap_busy", obs_busy, 1);
    expect_eq("edge_no_timeout", obs_err_to, 0);
    settle();

    // Calibration failure while waiting for completion is terminal.
    req_valid = 4'b0001;
    repeat (3) step_cycle();
    ddr_local_cal_fail = 1'b1;
    step_cycle();
    ddr_local_cal_fail = 1'b0;
    step_cycle();
    expect_eq("calfail_flag", obs_err_cf, 1);
    expect_eq("calfail_idle", obs_busy, 0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      req_valid      = '1;
      ddr_setup_done = k[0];
      cmd_done       = k[1];
      step_cycle();
      if (obs_send || obs_ready != 0 || obs_setup) seen++;
    end
    expect_eq("calfail_no_strobes", seen, 0);
    pulse_reset();
    step_cycle();
    expect_eq("calfail_cleared", obs_err_cf, 0);
    settle();
    req_valid = 4'b0100;
    step_cycle();
    expect_eq("calfail_recovered", obs_ready, 4'b0100);
    settle();

    // Setup never acknowledged: timeout drives the block into failure.
    pulse_reset();
    ddr_local_cal_success = 1'b1;
    ddr_setup_done        = 1'b0;
    repeat (TIMEOUT_CYC + 6) step_cycle();
    expect_eq("setup_timeout_flag", obs_err_to, 1);
    expect_eq("setup_timeout_idle", obs_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
